// File: rtl/blink_pkg.sv
// blink_pkg: shared definitions for the two-LED blink controller.
//   - blinkModeT : mode encoding (OFF=0, SLOW=1, FAST=2, ALT=3, ON=4)
//   - nextMode() : press-event successor OFF->SLOW->FAST->ALT->ON->OFF
//   - cntWidth() : bits needed for a counter that must hold 0..maxVal
package blink_pkg;

   typedef enum logic [2:0] {
      MODE_OFF  = 3'd0,
      MODE_SLOW = 3'd1,
      MODE_FAST = 3'd2,
      MODE_ALT  = 3'd3,
      MODE_ON   = 3'd4
   } blinkModeT;

   function automatic blinkModeT nextMode(input blinkModeT cur);
      blinkModeT nxt;
      case (cur)
         MODE_OFF:  nxt = MODE_SLOW;
         MODE_SLOW: nxt = MODE_FAST;
         MODE_FAST: nxt = MODE_ALT;
         MODE_ALT:  nxt = MODE_ON;
         default:   nxt = MODE_OFF;
      endcase
      return nxt;
   endfunction

   // Never returns less than 1 so a degenerate range still yields a legal vector.
   function automatic int cntWidth(input int maxVal);
      int w;
      w = $clog2(maxVal + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/blink_debounce.sv
// blink_debounce: button synchronizer, tick-driven debouncer and press-edge detector.
// Ports:
//   inCLK      system clock
//   inRESET    asynchronous active-low reset
//   inBTN      raw push button, active-low, asynchronous to inCLK
//   inTICK     1 ms tick pulse from the prescaler
//   outLEVEL   debounced button state, 1 = pressed
//   outPRESS   one-cycle pulse on the debounced released->pressed transition
module blink_debounce
   import blink_pkg::*;
#(
   parameter int DEBOUNCE_MS = 20
) (
   input  logic inCLK,
   input  logic inRESET,
   input  logic inBTN,
   input  logic inTICK,
   output logic outLEVEL,
   output logic outPRESS
);

   localparam int CW = cntWidth(DEBOUNCE_MS);

   logic          syncA;
   logic          syncB;
   logic          pressedLvl;
   logic          stateReg;
   logic [CW-1:0] cntReg;
   logic          pressReg;

   // Button idles high, so the synchronizer resets to the released level.
   assign pressedLvl = ~syncB;

   always_ff @(posedge inCLK or negedge inRESET) begin
      if (!inRESET) begin
         syncA    <= 1'b1;
         syncB    <= 1'b1;
         stateReg <= 1'b0;
         cntReg   <= '0;
         pressReg <= 1'b0;
      end else begin
         syncA    <= inBTN;
         syncB    <= syncA;
         pressReg <= 1'b0;
         if (inTICK) begin
            if (pressedLvl == stateReg) begin
               cntReg <= '0;
            end else if (cntReg == CW'(DEBOUNCE_MS - 1)) begin
               // This tick is the DEBOUNCE_MS-th disagreeing one: accept the new level.
               cntReg   <= '0;
               stateReg <= ~stateReg;
               pressReg <= ~stateReg;   // only the released->pressed flip is an event
            end else begin
               cntReg <= cntReg + CW'(1);
            end
         end
      end
   end

   assign outLEVEL = stateReg;
   assign outPRESS = pressReg;

endmodule

// File: rtl/blink_mode_ctrl.sv
// blink_mode_ctrl: push-button mode controller for the two-LED blinker.
// Steps OFF->SLOW->FAST->ALT->ON->OFF on each debounced press and blinks the
// LEDs from a run-time selected half-period driven by a free-running 1 ms prescaler.
// Ports:
//   inCLK      system clock
//   inRESET    asynchronous active-low reset
//   inBTN      push button, active-low, asynchronous
//   outLED0    LED 0, active-high, registered
//   outLED1    LED 1, active-high, registered
//   outMODE    current mode encoding, registered
// Optional feature macro: BLINK_LONGPRESS_EN -- holding the button for LONG_MS
// ticks forces the mode back to OFF once per hold.
module blink_mode_ctrl
   import blink_pkg::*;
#(
   parameter int TICK_DIV    = 50000,
   parameter int DEBOUNCE_MS = 20,
   parameter int SLOW_MS     = 500,
   parameter int FAST_MS     = 100,
   parameter int LONG_MS     = 1500
) (
   input  logic       inCLK,
   input  logic       inRESET,
   input  logic       inBTN,
   output logic       outLED0,
   output logic       outLED1,
   output logic [2:0] outMODE
);

   localparam int TW = cntWidth(TICK_DIV - 1);
   localparam int PW = cntWidth((SLOW_MS > FAST_MS) ? SLOW_MS : FAST_MS);

   logic [TW-1:0] tickCnt;
   logic          tick;
   logic          dbLevel;
   logic          pressEvt;
   logic          forceOff;
   blinkModeT     modeReg;
   logic [PW-1:0] phaseCnt;
   logic          phase;
   logic [PW-1:0] halfLast;
   logic          blinking;

   // Free-running prescaler; deliberately not realigned on mode changes.
   always_ff @(posedge inCLK or negedge inRESET) begin
      if (!inRESET) begin
         tickCnt <= '0;
      end else if (tickCnt == TW'(TICK_DIV - 1)) begin
         tickCnt <= '0;
      end else begin
         tickCnt <= tickCnt + TW'(1);
      end
   end

   assign tick = (tickCnt == TW'(TICK_DIV - 1));

   blink_debounce #(
      .DEBOUNCE_MS (DEBOUNCE_MS)
   ) uDebounce (
      .inCLK    (inCLK),
      .inRESET  (inRESET),
      .inBTN    (inBTN),
      .inTICK   (tick),
      .outLEVEL (dbLevel),
      .outPRESS (pressEvt)
   );

`ifdef BLINK_LONGPRESS_EN
   localparam int HW = cntWidth(LONG_MS);

   logic [HW-1:0] holdCnt;
   logic          longPulse;

   // Counter saturates at LONG_MS so the override fires only once per hold.
   always_ff @(posedge inCLK or negedge inRESET) begin
      if (!inRESET) begin
         holdCnt   <= '0;
         longPulse <= 1'b0;
      end else begin
         longPulse <= 1'b0;
         if (!dbLevel) begin
            holdCnt <= '0;
         end else if (tick && (holdCnt != HW'(LONG_MS))) begin
            holdCnt <= holdCnt + HW'(1);
            if (holdCnt == HW'(LONG_MS - 1)) begin
               longPulse <= 1'b1;
            end
         end
      end
   end

   assign forceOff = longPulse;
`else
   // Without long-press the debounced level and LONG_MS have no consumer.
   localparam int unusedLongMs = LONG_MS;
   logic unusedLevel;
   assign unusedLevel = dbLevel;
   assign forceOff    = 1'b0;
`endif

   assign blinking = (modeReg == MODE_SLOW) || (modeReg == MODE_FAST) || (modeReg == MODE_ALT);
   assign halfLast = (modeReg == MODE_FAST) ? PW'(FAST_MS - 1) : PW'(SLOW_MS - 1);

   // Mode FSM, phase counter and registered LED/mode decode.
   always_ff @(posedge inCLK or negedge inRESET) begin
      if (!inRESET) begin
         modeReg  <= MODE_OFF;
         phaseCnt <= '0;
         phase    <= 1'b0;
         outLED0  <= 1'b0;
         outLED1  <= 1'b0;
         outMODE  <= 3'd0;
      end else begin
         if (forceOff || pressEvt) begin
            // A mode change outranks a coincident phase wrap.
            modeReg  <= forceOff ? MODE_OFF : nextMode(modeReg);
            phaseCnt <= '0;
            phase    <= 1'b1;
         end else if (blinking) begin
            if (tick) begin
               if (phaseCnt == halfLast) begin
                  phaseCnt <= '0;
                  phase    <= ~phase;
               end else begin
                  phaseCnt <= phaseCnt + PW'(1);
               end
            end
         end else begin
            phaseCnt <= '0;
            phase    <= 1'b1;
         end

         case (modeReg)
            MODE_SLOW, MODE_FAST: begin
               outLED0 <= phase;
               outLED1 <= phase;
            end
            MODE_ALT: begin
               outLED0 <= phase;
               outLED1 <= ~phase;
            end
            MODE_ON: begin
               outLED0 <= 1'b1;
               outLED1 <= 1'b1;
            end
            default: begin
               outLED0 <= 1'b0;
               outLED1 <= 1'b0;
            end
         endcase
         outMODE <= modeReg;
      end
   end

endmodule

// File: tb/tb_blink_mode_ctrl.sv
// tb_blink_mode_ctrl: directed bench for blink_mode_ctrl with a mode scoreboard.
// Each press pushes the mode the model predicts; a monitor pops and compares
// whenever outMODE changes. LED timing and decode are checked inline.
module tb_blink_mode_ctrl;

   logic       inCLK;
   logic       inRESET;
   logic       inBTN;
   logic       outLED0;
   logic       outLED1;
   logic [2:0] outMODE;

   int passCnt  = 0;
   int totalCnt = 0;
   int failCnt  = 0;
   int cyc      = 0;
   int expMode  = 0;
   int expQ[$];

   blink_mode_ctrl #(
      .TICK_DIV    (4),
      .DEBOUNCE_MS (3),
      .SLOW_MS     (8),
      .FAST_MS     (2),
      .LONG_MS     (10)
   ) dut (
      .inCLK   (inCLK),
      .inRESET (inRESET),
      .inBTN   (inBTN),
      .outLED0 (outLED0),
      .outLED1 (outLED1),
      .outMODE (outMODE)
   );

   initial inCLK = 1'b0;
   always #5 inCLK = ~inCLK;
   always @(posedge inCLK) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      totalCnt++;
      assert (obs === exp) passCnt++;
      else begin
         failCnt++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Scoreboard monitor: every outMODE change must match the oldest prediction.
   initial begin
      logic [2:0] prevMode;
      int         e;
      prevMode = 3'd0;
      forever begin
         @(negedge inCLK);
         if (!inRESET) begin
            prevMode = outMODE;
         end else if (outMODE !== prevMode) begin
            if (expQ.size() == 0) begin
               check("spurious_mode_change", {29'd0, outMODE}, {29'd0, prevMode});
            end else begin
               e = expQ.pop_front();
               check("mode_seq", {29'd0, outMODE}, e);
            end
            $display("mode change at cycle %0d: %0d -> %0d (LED %0d/%0d)",
                     cyc, prevMode, outMODE, outLED0, outLED1);
            prevMode = outMODE;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic pushNext();
      expMode = (expMode == 4) ? 0 : expMode + 1;
      expQ.push_back(expMode);
   endtask

   task automatic waitDrain(input int limit, input string tag);
      for (int i = 0; i < limit && expQ.size() != 0; i++) @(negedge inCLK);
      check(tag, expQ.size(), 0);
   endtask

   task automatic releaseBtn();
      inBTN = 1'b1;
      repeat (30) @(negedge inCLK);
   endtask

   task automatic pressClean(input string tag);
      pushNext();
      inBTN = 1'b0;
      waitDrain(100, tag);
      repeat (5) @(negedge inCLK);
      releaseBtn();
   endtask

   task automatic waitLedEdge(input int limit, output int at, output bit ok);
      logic prev;
      prev = outLED0;
      ok   = 1'b0;
      at   = 0;
      for (int i = 0; i < limit; i++) begin
         @(negedge inCLK);
         if (outLED0 !== prev) begin
            ok = 1'b1;
            at = cyc;
            break;
         end
      end
   endtask

   initial begin
      int   t0;
      int   t1;
      bit   ok0;
      bit   ok1;
      int   bad;
      int   toggles;
      logic prevLed;
      logic [2:0] seenMode;
      bit   changed;

      // ---- reset ----
      inBTN   = 1'b1;
      inRESET = 1'b0;
      repeat (3) @(negedge inCLK);
      check("reset_led0", outLED0, 0);
      check("reset_led1", outLED1, 0);
      check("reset_mode", outMODE, 0);
      #2 inRESET = 1'b1;
      repeat (40) @(negedge inCLK);
      check("idle_led0", outLED0, 0);
      check("idle_led1", outLED1, 0);
      check("idle_mode", outMODE, 0);

      // ---- bounce: 5 low, 3 high, then held -> one event ----
      pushNext();
      inBTN = 1'b0;
      repeat (5) @(negedge inCLK);
      inBTN = 1'b1;
      repeat (3) @(negedge inCLK);
      inBTN = 1'b0;
      waitDrain(100, "bounce_event");
      repeat (40) @(negedge inCLK);
      check("bounce_single_event", outMODE, 1);
      releaseBtn();

      // SLOW: full half-period 8 ticks x 4 cycles
      waitLedEdge(100, t0, ok0);
      waitLedEdge(100, t1, ok1);
      check("slow_edges_seen", {ok0, ok1}, 2'b11);
      check("slow_half_period", t1 - t0, 32);
      check("slow_leds_equal", outLED1, outLED0);

      // ---- FAST ----
      pressClean("press_fast");
      waitLedEdge(50, t0, ok0);
      waitLedEdge(50, t1, ok1);
      check("fast_edges_seen", {ok0, ok1}, 2'b11);
      check("fast_half_period", t1 - t0, 8);
      check("fast_leds_equal", outLED1, outLED0);

      // ---- ALT ----
      pressClean("press_alt");
      bad     = 0;
      toggles = 0;
      prevLed = outLED0;
      for (int i = 0; i < 80; i++) begin
         @(negedge inCLK);
         if (outLED1 !== ~outLED0) bad++;
         if (outLED0 !== prevLed) toggles++;
         prevLed = outLED0;
      end
      check("alt_inverse", bad, 0);
      check("alt_blinks", toggles > 0, 1);

      // ---- ON / OFF ----
      pressClean("press_on");
      check("on_led0", outLED0, 1);
      check("on_led1", outLED1, 1);
      pressClean("press_off");
      check("off_led0", outLED0, 0);
      check("off_led1", outLED1, 0);
      pressClean("press_slow");

      // ---- mode change during blink: press SLOW->FAST while LEDs are 0 ----
      ok0 = 1'b0;
      prevLed = outLED0;
      for (int i = 0; i < 100; i++) begin
         @(negedge inCLK);
         if (prevLed === 1'b1 && outLED0 === 1'b0) begin
            ok0 = 1'b1;
            break;
         end
         prevLed = outLED0;
      end
      check("slow_falling_edge_seen", ok0, 1);
      pushNext();
      inBTN    = 1'b0;
      seenMode = outMODE;
      prevLed  = outLED0;
      changed  = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge inCLK);
         if (outMODE !== seenMode) begin
            changed = 1'b1;
            break;
         end
         prevLed = outLED0;
      end
      check("chg_event_seen", changed, 1);
      check("chg_led_before", prevLed, 0);
      check("chg_led0_after", outLED0, 1);
      check("chg_led1_after", outLED1, 1);
      t0 = cyc;
      waitLedEdge(50, t1, ok1);
      check("chg_next_toggle_seen", ok1, 1);
      check("chg_first_half_range", (t1 - t0 >= 5) && (t1 - t0 <= 8), 1);
      releaseBtn();

      // ---- reset mid-operation in ALT during a debounce ----
      pressClean("press_alt2");
      check("alt2_mode", outMODE, 3);
      inBTN = 1'b0;
      repeat (6) @(negedge inCLK);
      #2 inRESET = 1'b0;
      #1;
      check("midrst_led0", outLED0, 0);
      check("midrst_led1", outLED1, 0);
      check("midrst_mode", outMODE, 0);
      repeat (5) @(negedge inCLK);
      expMode = 0;
      #2 inRESET = 1'b1;
      pushNext();
      repeat (5) @(negedge inCLK);
      check("midrst_restart_mode", outMODE, 0);
      waitDrain(100, "midrst_event");
      releaseBtn();

      // ---- hold from SLOW ----
      pushNext();
`ifdef BLINK_LONGPRESS_EN
      expMode = 0;
      expQ.push_back(0);
`endif
      inBTN = 1'b0;
      waitDrain(150, "hold_events");
      repeat (100) @(negedge inCLK);
`ifdef BLINK_LONGPRESS_EN
      check("hold_mode", outMODE, 0);
`else
      check("hold_mode", outMODE, 2);
`endif
      releaseBtn();
      check("final_queue_empty", expQ.size(), 0);

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
